// File: rtl/trans_req_arbiter.sv
// Round-robin arbiter sharing one transceiver channel between 1<<REQ_BIT requesters,
// one transaction outstanding at a time. Optional WAIT timeout: `TRANS_ARB_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; grant next requester, drain stale replies
//   ST_ISSUE | holding latched {len, payload} until write FIFO has room
//   ST_WAIT  | request pushed, waiting for the reply in the read FIFO
//   ST_RESP  | one-cycle response pulse to the owner
module trans_req_arbiter #(
    parameter int REQ_BIT     = 1,
    parameter int MESSAGE_BIT = 64,
    parameter int TIMEOUT     = 255,
    localparam int N          = 1 << REQ_BIT
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N-1:0]             req_valid,
    input  logic [N*MESSAGE_BIT-1:0] req_data,
    input  logic [N*5-1:0]           req_len,
    output logic [N-1:0]             req_ready,
    output logic [N-1:0]             rsp_valid,
    output logic [MESSAGE_BIT-1:0]   rsp_data,
    output logic [4:0]               rsp_len,
    output logic                     rsp_err,
    output logic                     tx_write_flag,
    output logic [MESSAGE_BIT+4:0]   tx_write_data,
    input  logic                     tx_writable,
    output logic                     rx_read_flag,
    input  logic [MESSAGE_BIT+4:0]   rx_read_data,
    input  logic                     rx_readable,
    output logic                     busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    localparam logic [5:0] MAX_LEN = 6'(MESSAGE_BIT / 8);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("trans_req_arbiter: TIMEOUT must be 1..255");
    end

    state_t                 state, state_nxt;
    logic [REQ_BIT-1:0]     owner, last_grant;
    logic [REQ_BIT-1:0]     cand, grant_idx;
    logic                   grant_ok;
    logic [4:0]             len_q, sel_len, clamp_len;
    logic [MESSAGE_BIT-1:0] data_q, rsp_data_q;
    logic [4:0]             rsp_len_q;
`ifdef TRANS_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);
    logic [7:0]             timer;
    logic                   err_q;
`endif

    // Scan last_grant+1 .. last_grant+N; the REQ_BIT-wide add wraps mod N.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        for (int i = 1; i <= N; i++) begin
            cand = last_grant + REQ_BIT'(i);
            if (!grant_ok && req_valid[cand]) begin
                grant_ok  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_len   = req_len[int'(grant_idx) * 5 +: 5];
    assign clamp_len = ({1'b0, sel_len} > MAX_LEN) ? MAX_LEN[4:0] : sel_len;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Mealy outputs; IDLE outputs are gated by RST_N so reset forces them low.
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_err       = 1'b0;
        tx_write_flag = 1'b0;
        rx_read_flag  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RST_N) begin
                    rx_read_flag = rx_readable;
                    if (grant_ok) begin
                        req_ready[grant_idx] = 1'b1;
                        state_nxt            = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (tx_writable) begin
                    tx_write_flag = 1'b1;
                    state_nxt     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rx_readable) begin
                    rx_read_flag = 1'b1;
                    state_nxt    = ST_RESP;
                end
`ifdef TRANS_ARB_TIMEOUT_EN
                else if (timer == TIMEOUT_8) begin
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
`ifdef TRANS_ARB_TIMEOUT_EN
                rsp_err          = err_q;
`endif
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner      <= '0;
            last_grant <= '1;
            len_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_len_q  <= '0;
`ifdef TRANS_ARB_TIMEOUT_EN
            timer      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && grant_ok) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                len_q      <= clamp_len;
                data_q     <= req_data[int'(grant_idx) * MESSAGE_BIT +: MESSAGE_BIT];
            end
            if (state == ST_WAIT && rx_readable) begin
                rsp_data_q <= rx_read_data[MESSAGE_BIT-1:0];
                rsp_len_q  <= rx_read_data[MESSAGE_BIT +: 5];
`ifdef TRANS_ARB_TIMEOUT_EN
                err_q      <= 1'b0;
`endif
            end
`ifdef TRANS_ARB_TIMEOUT_EN
            if (state == ST_ISSUE && tx_writable) timer <= '0;
            // Timeout is tested before the increment, so a reply in the same cycle wins.
            if (state == ST_WAIT && !rx_readable) begin
                if (timer == TIMEOUT_8) begin
                    rsp_data_q <= '0;
                    rsp_len_q  <= '0;
                    err_q      <= 1'b1;
                end else begin
                    timer <= timer + 8'd1;
                end
            end
`endif
        end
    end

    assign rsp_data      = rsp_data_q;
    assign rsp_len       = rsp_len_q;
    assign tx_write_data = {len_q, data_q};
    assign busy          = (state != ST_IDLE);

endmodule
